// File: rtl/syncram_master_if.sv
// rtl/syncram_master_if.sv - request/response channel and syncram port interfaces
interface mem_req_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface syncram_if #(
  parameter int ADDR_W = 32
);
  logic              cs;
  logic              oe;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       din;
  logic [31:0]       dout;

  modport master (
    output cs, oe, we, addr, din,
    input  dout
  );

  modport slave (
    input  cs, oe, we, addr, din,
    output dout
  );
endinterface

// File: rtl/syncram_master.sv
// rtl/syncram_master.sv - load/store sequencer for a syncram port with read-modify-write sub-word stores
module syncram_master #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic      clk,
  input  logic      rst,
  mem_req_if.slave  req,
  syncram_if.master mem
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        we_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        accept;
  logic        acc_err;
  logic        cs_nxt, oe_nxt, we_nxt;
  logic        rv_nxt, err_nxt;
  logic [31:0] din_nxt, rdata_nxt;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    misaligned = (sz == 2'b11) ||
                 (sz == 2'b01 && lo[0]) ||
                 (sz == 2'b10 && lo != 2'b00);
  endfunction

  // Big-endian lanes: byte shift is (3-lo)*8, half shift is 16 when lo[1]=0.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] lo);
    logic [4:0] bsh;
    logic [4:0] hsh;
    bsh = {~lo, 3'b000};
    hsh = {~lo[1], 4'b0000};
    case (sz)
      2'b00:   extract = (w >> bsh) & 32'h0000_00FF;
      2'b01:   extract = (w >> hsh) & 32'h0000_FFFF;
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] wd,
                                        input logic [1:0] sz, input logic [1:0] lo);
    logic [4:0] bsh;
    logic [4:0] hsh;
    bsh = {~lo, 3'b000};
    hsh = {~lo[1], 4'b0000};
    case (sz)
      2'b00:   merge = (w & ~(32'h0000_00FF << bsh)) | ({24'h0, wd[7:0]} << bsh);
      2'b01:   merge = (w & ~(32'h0000_FFFF << hsh)) | ({16'h0, wd} << hsh);
      default: merge = w;
    endcase
  endfunction

  assign req.req_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    din_nxt   = 32'h0;
    rdata_nxt = 32'h0;
    err_nxt   = 1'b0;
    accept    = (state == IDLE) && req.req_valid;
    acc_err   = misaligned(req.req_size, req.req_addr[1:0]);

    case (state)
      IDLE: begin
        if (req.req_valid) begin
          if (acc_err) begin
            state_nxt = RESP;
            err_nxt   = 1'b1;
          end else if (!req.req_we || req.req_size != 2'b10) begin
            state_nxt = RD;
            cnt_nxt   = CNT_INIT;
          end else begin
            state_nxt = WR;
            din_nxt   = req.req_wdata;
          end
        end
      end
      RD: begin
        // mem.dout is valid on the last strobe cycle; it is consumed directly
        // into the registered write word or response data at that edge.
        if (cnt == 3'd0) begin
          if (we_q) begin
            state_nxt = WR;
            din_nxt   = merge(mem.dout, wdata_q, size_q, lane_q);
          end else begin
            state_nxt = RESP;
            rdata_nxt = extract(mem.dout, size_q, lane_q);
          end
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    cs_nxt = (state_nxt == RD) || (state_nxt == WR);
    oe_nxt = (state_nxt == RD);
    we_nxt = (state_nxt == WR);
    rv_nxt = (state_nxt == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      lane_q        <= 2'b00;
      wdata_q       <= 16'h0;
      mem.cs        <= 1'b0;
      mem.oe        <= 1'b0;
      mem.we        <= 1'b0;
      mem.addr      <= '0;
      mem.din       <= 32'h0;
      req.rsp_valid <= 1'b0;
      req.rsp_err   <= 1'b0;
      req.rsp_rdata <= 32'h0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      mem.cs        <= cs_nxt;
      mem.oe        <= oe_nxt;
      mem.we        <= we_nxt;
      mem.din       <= din_nxt;
      req.rsp_valid <= rv_nxt;
      req.rsp_err   <= err_nxt;
      req.rsp_rdata <= rdata_nxt;
      if (accept) begin
        we_q     <= req.req_we;
        size_q   <= req.req_size;
        lane_q   <= req.req_addr[1:0];
        wdata_q  <= req.req_wdata[15:0];
        mem.addr <= {req.req_addr[ADDR_W-1:2], 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_syncram_master.sv
// tb/tb_syncram_master.sv - directed self-checking bench for syncram_master at READ_LAT 1 and 3
module tb_syncram_master;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        req_valid, req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        ld_en;
  int          ld_sel;
  logic [31:0] ld_addr, ld_data, peek_addr;

  logic        cs_a[2], oe_a[2], we_a[2], rv_a[2], err_a[2], rdy_a[2];
  logic [31:0] addr_a[2], din_a[2], rd_a[2], peek_a[2];

  logic        t_cs[10], t_oe[10], t_we[10], t_rv[10], t_err[10], t_rdy[10];
  logic [31:0] t_addr[10], t_din[10], t_rd[10];
  logic        t_rdy0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;
    mem_req_if #(.ADDR_W(32)) rq ();
    syncram_if #(.ADDR_W(32)) sr ();
    logic [31:0] ram [256];
    logic [31:0] rd_now;

    syncram_master #(.READ_LAT(LAT), .ADDR_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .req(rq.slave),
      .mem(sr.master)
    );

    assign rq.req_valid = req_valid && (sel == g);
    assign rq.req_we    = req_we;
    assign rq.req_size  = req_size;
    assign rq.req_addr  = req_addr;
    assign rq.req_wdata = req_wdata;

    assign cs_a[g]   = sr.cs;
    assign oe_a[g]   = sr.oe;
    assign we_a[g]   = sr.we;
    assign addr_a[g] = sr.addr;
    assign din_a[g]  = sr.din;
    assign rv_a[g]   = rq.rsp_valid;
    assign err_a[g]  = rq.rsp_err;
    assign rd_a[g]   = rq.rsp_rdata;
    assign rdy_a[g]  = rq.req_ready;
    assign peek_a[g] = ram[peek_addr[9:2]];

    assign rd_now = (sr.cs && sr.oe && !sr.we) ? ram[sr.addr[9:2]] : 32'hDEAD_BEEF;

    always_ff @(posedge clk) begin
      if (ld_en && ld_sel == g) ram[ld_addr[9:2]] <= ld_data;
      else if (sr.cs && sr.we) ram[sr.addr[9:2]] <= sr.din;
    end

    if (LAT == 1) begin : lat1
      assign sr.dout = rd_now;
    end else begin : lat3
      logic [31:0] p0, p1;
      always_ff @(posedge clk) begin
        p0 <= rd_now;
        p1 <= p0;
      end
      assign sr.dout = p1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sample(input int c);
    t_cs[c]   = cs_a[sel];
    t_oe[c]   = oe_a[sel];
    t_we[c]   = we_a[sel];
    t_rv[c]   = rv_a[sel];
    t_err[c]  = err_a[sel];
    t_rdy[c]  = rdy_a[sel];
    t_addr[c] = addr_a[sel];
    t_din[c]  = din_a[sel];
    t_rd[c]   = rd_a[sel];
  endtask

  // Drives a request in cycle 0, holds req_valid through cycle 'hold', traces cycles 1..9.
  task automatic issue(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int hold);
    @(negedge clk);
    t_rdy0    = rdy_a[sel];
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      sample(c);
      if (c >= hold) req_valid = 1'b0;
    end
  endtask

  task automatic preload(input int s, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_sel  = s;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic peek(input int s, input logic [31:0] a, output logic [31:0] v);
    peek_addr = a;
    #1;
    v = peek_a[s];
  endtask

  function automatic int first_rv();
    for (int c = 1; c <= 9; c++) if (t_rv[c]) return c;
    return 0;
  endfunction

  function automatic int n_rv();
    int n = 0;
    for (int c = 1; c <= 9; c++) if (t_rv[c]) n++;
    return n;
  endfunction

  function automatic int n_cs();
    int n = 0;
    for (int c = 1; c <= 9; c++) if (t_cs[c]) n++;
    return n;
  endfunction

  task automatic check_idle_outputs(input string tag, input int s);
    check({tag, "_strobes"}, {27'h0, cs_a[s], oe_a[s], we_a[s], rv_a[s], err_a[s]}, 32'h0);
    check({tag, "_addr"}, addr_a[s], 32'h0);
    check({tag, "_din"}, din_a[s], 32'h0);
    check({tag, "_rdata"}, rd_a[s], 32'h0);
    check({tag, "_ready"}, {31'h0, rdy_a[s]}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          cnt;
    rst = 1'b1; sel = 0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_addr = 32'h0; req_wdata = 32'h0; ld_en = 1'b0; ld_sel = 0;
    ld_addr = 32'h0; ld_data = 32'h0; peek_addr = 32'h0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst_l1", 0);
    check_idle_outputs("rst_l3", 1);
    rst = 1'b0;

    // 1: word load, READ_LAT=1
    preload(0, 32'h0040_0050, 32'h8C0A_0004);
    issue(1'b0, 2'b10, 32'h0040_0050, 32'h0, 1);
    check("t1_ready0", {31'h0, t_rdy0}, 32'h1);
    check("t1_strobe1", {29'h0, t_cs[1], t_oe[1], t_we[1]}, 32'b110);
    check("t1_addr1", t_addr[1], 32'h0040_0050);
    check("t1_cs2", {31'h0, t_cs[2]}, 32'h0);
    check("t1_rsp_cycle", first_rv(), 2);
    check("t1_rsp_count", n_rv(), 1);
    check("t1_rdata", t_rd[2], 32'h8C0A_0004);
    check("t1_err", {31'h0, t_err[2]}, 32'h0);
    check("t1_ready123", {29'h0, t_rdy[1], t_rdy[2], t_rdy[3]}, 32'b001);

    // 2: word store then readback
    issue(1'b1, 2'b10, 32'h1000_0024, 32'h0000_000E, 1);
    check("t2_strobe1", {29'h0, t_cs[1], t_oe[1], t_we[1]}, 32'b101);
    check("t2_din1", t_din[1], 32'h0000_000E);
    check("t2_din2", t_din[2], 32'h0);
    check("t2_rsp_cycle", first_rv(), 2);
    check("t2_rdata", t_rd[2], 32'h0);
    issue(1'b0, 2'b10, 32'h1000_0024, 32'h0, 1);
    check("t2_readback", t_rd[2], 32'h0000_000E);

    // 3: byte store as read-modify-write
    preload(0, 32'h1000_0024, 32'h1122_3344);
    issue(1'b1, 2'b00, 32'h1000_0025, 32'h0000_00AB, 1);
    check("t3_strobe1", {29'h0, t_cs[1], t_oe[1], t_we[1]}, 32'b110);
    check("t3_addr1", t_addr[1], 32'h1000_0024);
    check("t3_strobe2", {29'h0, t_cs[2], t_oe[2], t_we[2]}, 32'b101);
    check("t3_din2", t_din[2], 32'h11AB_3344);
    check("t3_rsp_cycle", first_rv(), 3);
    peek(0, 32'h1000_0024, v);
    check("t3_ram", v, 32'h11AB_3344);
    issue(1'b0, 2'b00, 32'h1000_0025, 32'h0, 1);
    check("t3_byte_load", t_rd[2], 32'h0000_00AB);
    issue(1'b0, 2'b00, 32'h1000_0027, 32'h0, 1);
    check("t3_byte3_load", t_rd[2], 32'h0000_0044);

    // 4: half load and misaligned errors
    issue(1'b0, 2'b01, 32'h1000_0026, 32'h0, 1);
    check("t4_half_load", t_rd[2], 32'h0000_3344);
    issue(1'b0, 2'b01, 32'h1000_0023, 32'h0, 1);
    check("t4_err_cycle", first_rv(), 1);
    check("t4_err", {31'h0, t_err[1]}, 32'h1);
    check("t4_err_rdata", t_rd[1], 32'h0);
    check("t4_err_no_cs", n_cs(), 0);
    issue(1'b0, 2'b11, 32'h1000_0024, 32'h0, 1);
    check("t4_size3_err", {31'h0, t_err[1]}, 32'h1);
    check("t4_size3_no_cs", n_cs(), 0);
    issue(1'b1, 2'b10, 32'h1000_0026, 32'hFFFF_FFFF, 1);
    check("t4_wmis_err", {30'h0, t_rv[1], t_err[1]}, 32'b11);
    check("t4_wmis_no_cs", n_cs(), 0);

    // half store into the upper lane
    issue(1'b1, 2'b01, 32'h1000_0024, 32'h1234_BEEF, 1);
    check("t4_half_din", t_din[2], 32'hBEEF_3344);
    peek(0, 32'h1000_0024, v);
    check("t4_half_ram", v, 32'hBEEF_3344);

    // 5: READ_LAT=3 with req_valid held high
    sel = 1;
    preload(1, 32'h0040_0050, 32'h8C0A_0004);
    issue(1'b0, 2'b10, 32'h0040_0050, 32'h0, 4);
    check("t5_cs", {28'h0, t_cs[1], t_cs[2], t_cs[3], t_cs[4]}, 32'b1110);
    check("t5_oe", {28'h0, t_oe[1], t_oe[2], t_oe[3], t_oe[4]}, 32'b1110);
    check("t5_rsp_cycle", first_rv(), 4);
    check("t5_rdata", t_rd[4], 32'h8C0A_0004);
    check("t5_ready", {27'h0, t_rdy[1], t_rdy[2], t_rdy[3], t_rdy[4], t_rdy[5]}, 32'b00001);
    check("t5_rsp_count", n_rv(), 1);
    issue(1'b1, 2'b00, 32'h0040_0053, 32'h0000_00CD, 1);
    check("t5_sub_we", {27'h0, t_we[1], t_we[2], t_we[3], t_we[4], t_we[5]}, 32'b00010);
    check("t5_sub_din", t_din[4], 32'h8C0A_00CD);
    check("t5_sub_rsp", first_rv(), 5);

    // 6: reset during RD of a byte store
    sel = 0;
    preload(0, 32'h1000_0020, 32'h5566_7788);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
    req_addr = 32'h1000_0021; req_wdata = 32'h0000_0099;
    @(negedge clk);
    check("t6_started", {31'h0, cs_a[0]}, 32'h1);
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("t6_after_rst", 0);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rv_a[0] || we_a[0]) cnt++;
    end
    check("t6_no_rsp_no_wr", cnt, 0);
    peek(0, 32'h1000_0020, v);
    check("t6_ram", v, 32'h5566_7788);
    issue(1'b0, 2'b10, 32'h1000_0020, 32'h0, 1);
    check("t6_load_cycle", first_rv(), 2);
    check("t6_load_rdata", t_rd[2], 32'h5566_7788);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
